// File: rtl/decode_stage.sv
// Decode stage: field/immediate decode, 8x16 register file with WB bypass, load-use stall, D/X pipe register.
// Latency: 1 cycle from F/D instruction to D/X outputs; Stall is combinational.
// Backpressure: Stall holds fetch and F/D and inserts a bubble; Flush kills D and overrides Stall.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Instr,
  input  logic [15:0] IncPC,
  input  logic        Flush,
  input  logic        WbRegWrite,
  input  logic [2:0]  WbReg,
  input  logic [15:0] WbData,
  output logic        Stall,
  output logic [15:0] RsData_Out,
  output logic [15:0] RtData_Out,
  output logic [15:0] Imm_Out,
  output logic [15:0] IncPC_Out,
  output logic [4:0]  Opcode_Out,
  output logic [1:0]  Funct_Out,
  output logic [2:0]  Rs_Out,
  output logic [2:0]  Rt_Out,
  output logic [2:0]  DestReg_Out,
  output logic        RegWrite_Out,
  output logic        MemRead_Out,
  output logic        MemWrite_Out,
  output logic        Halt_Out,
  output logic        Valid_Out
);

  typedef struct packed {
    logic [15:0] rs_dat;
    logic [15:0] rt_dat;
    logic [15:0] imm;
    logic [15:0] inc_pc;
    logic [4:0]  opcode;
    logic [1:0]  funct;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        halt;
    logic        valid;
  } dx_t;

  // Bubble: everything zero except the NOP opcode.
  localparam dx_t BUBBLE = '{opcode: 5'b00001, default: '0};

  logic [15:0] rf_q [8];
  dx_t         dx_d, dx_q;

  logic [4:0]  op;
  logic [2:0]  rs_idx, rt_idx;
  logic [15:0] rs_dat, rt_dat;
  logic [15:0] imm;
  logic [2:0]  dest;
  logic        reads_rs, reads_rt, reg_write, mem_read, mem_write, halt;

  assign op     = Instr[15:11];
  assign rs_idx = Instr[10:8];
  assign rt_idx = Instr[7:5];

  // Instruction class decode: operand usage, destination, immediate and control bits.
  always_comb begin
    reads_rs  = 1'b0;
    reads_rt  = 1'b0;
    reg_write = 1'b0;
    dest      = 3'd0;
    imm       = 16'h0000;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    halt      = 1'b0;
    casez (op)
      5'b11011, 5'b11010, 5'b111??, 5'b11001: begin
        reads_rs = 1'b1; reads_rt = 1'b1; reg_write = 1'b1; dest = Instr[4:2];
      end
      5'b0100?: begin
        reads_rs = 1'b1; reg_write = 1'b1; dest = rt_idx;
        imm = {{11{Instr[4]}}, Instr[4:0]};
      end
      5'b0101?, 5'b101??: begin
        reads_rs = 1'b1; reg_write = 1'b1; dest = rt_idx;
        imm = {11'd0, Instr[4:0]};
      end
      5'b10001: begin
        reads_rs = 1'b1; reg_write = 1'b1; dest = rt_idx; mem_read = 1'b1;
        imm = {{11{Instr[4]}}, Instr[4:0]};
      end
      5'b10000: begin
        reads_rs = 1'b1; reads_rt = 1'b1; mem_write = 1'b1;
        imm = {{11{Instr[4]}}, Instr[4:0]};
      end
      5'b10011: begin
        reads_rs = 1'b1; reads_rt = 1'b1; mem_write = 1'b1; reg_write = 1'b1; dest = rs_idx;
        imm = {{11{Instr[4]}}, Instr[4:0]};
      end
      5'b11000: begin
        reg_write = 1'b1; dest = rs_idx;
        imm = {{8{Instr[7]}}, Instr[7:0]};
      end
      5'b10010: begin
        reads_rs = 1'b1; reg_write = 1'b1; dest = rs_idx;
        imm = {8'd0, Instr[7:0]};
      end
      5'b011??, 5'b00101: begin
        reads_rs = 1'b1;
        imm = {{8{Instr[7]}}, Instr[7:0]};
      end
      5'b00111: begin
        reads_rs = 1'b1; reg_write = 1'b1; dest = 3'd7;
        imm = {{8{Instr[7]}}, Instr[7:0]};
      end
      5'b00100: begin
        imm = {{5{Instr[10]}}, Instr[10:0]};
      end
      5'b00110: begin
        reg_write = 1'b1; dest = 3'd7;
        imm = {{5{Instr[10]}}, Instr[10:0]};
      end
      5'b00000: halt = 1'b1;
      default: ;
    endcase
  end

  // Register file reads with same-cycle write-back bypass.
  assign rs_dat = (WbRegWrite && (WbReg == rs_idx)) ? WbData : rf_q[rs_idx];
  assign rt_dat = (WbRegWrite && (WbReg == rt_idx)) ? WbData : rf_q[rt_idx];

  // Load-use hazard against the load currently in D/X; a flush makes it moot.
  assign Stall = ~Flush & dx_q.valid & dx_q.mem_read &
                 ((reads_rs & (rs_idx == dx_q.dest)) | (reads_rt & (rt_idx == dx_q.dest)));

  // Next D/X contents: bubble on flush or stall, otherwise the decoded instruction.
  always_comb begin
    dx_d = BUBBLE;
    if (!Flush && !Stall) begin
      dx_d.rs_dat    = rs_dat;
      dx_d.rt_dat    = rt_dat;
      dx_d.imm       = imm;
      dx_d.inc_pc    = IncPC;
      dx_d.opcode    = op;
      dx_d.funct     = Instr[1:0];
      dx_d.rs        = rs_idx;
      dx_d.rt        = rt_idx;
      dx_d.dest      = dest;
      dx_d.reg_write = reg_write;
      dx_d.mem_read  = mem_read;
      dx_d.mem_write = mem_write;
      dx_d.halt      = halt;
      dx_d.valid     = 1'b1;
    end
  end

  // D/X pipe register; reset loads a bubble.
  always_ff @(posedge clk) begin
    if (rst) dx_q <= BUBBLE;
    else     dx_q <= dx_d;
  end

  // Architectural register file; WB writes are independent of stall/flush, reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= 16'h0000;
    end else if (WbRegWrite) begin
      rf_q[WbReg] <= WbData;
    end
  end

  assign RsData_Out   = dx_q.rs_dat;
  assign RtData_Out   = dx_q.rt_dat;
  assign Imm_Out      = dx_q.imm;
  assign IncPC_Out    = dx_q.inc_pc;
  assign Opcode_Out   = dx_q.opcode;
  assign Funct_Out    = dx_q.funct;
  assign Rs_Out       = dx_q.rs;
  assign Rt_Out       = dx_q.rt;
  assign DestReg_Out  = dx_q.dest;
  assign RegWrite_Out = dx_q.reg_write;
  assign MemRead_Out  = dx_q.mem_read;
  assign MemWrite_Out = dx_q.mem_write;
  assign Halt_Out     = dx_q.halt;
  assign Valid_Out    = dx_q.valid;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vectors, expected D/X contents queued by the driver.
// A monitor pops one expectation per clock edge and compares it to the D/X outputs.
// Stall is checked by the driver just before each edge.
module tb_decode_stage;

  typedef struct packed {
    logic [15:0] rsd, rtd, imm, pc;
    logic [4:0]  op;
    logic [1:0]  fn;
    logic [2:0]  rs, rt, dst;
    logic        rw, mr, mw, hl, vl;
  } dx_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Instr = 16'h0000, IncPC = 16'h0000, WbData = 16'h0000;
  logic        Flush = 1'b0, WbRegWrite = 1'b0;
  logic [2:0]  WbReg = 3'd0;
  logic        Stall;
  logic [15:0] RsData_Out, RtData_Out, Imm_Out, IncPC_Out;
  logic [4:0]  Opcode_Out;
  logic [1:0]  Funct_Out;
  logic [2:0]  Rs_Out, Rt_Out, DestReg_Out;
  logic        RegWrite_Out, MemRead_Out, MemWrite_Out, Halt_Out, Valid_Out;

  int   total = 0;
  int   passed = 0;
  dx_t  sb [$];

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .Instr(Instr), .IncPC(IncPC), .Flush(Flush),
    .WbRegWrite(WbRegWrite), .WbReg(WbReg), .WbData(WbData), .Stall(Stall),
    .RsData_Out(RsData_Out), .RtData_Out(RtData_Out), .Imm_Out(Imm_Out),
    .IncPC_Out(IncPC_Out), .Opcode_Out(Opcode_Out), .Funct_Out(Funct_Out),
    .Rs_Out(Rs_Out), .Rt_Out(Rt_Out), .DestReg_Out(DestReg_Out),
    .RegWrite_Out(RegWrite_Out), .MemRead_Out(MemRead_Out), .MemWrite_Out(MemWrite_Out),
    .Halt_Out(Halt_Out), .Valid_Out(Valid_Out)
  );

  function automatic dx_t mk(input logic [15:0] rsd, rtd, imm, pc, input logic [4:0] op,
                             input logic [1:0] fn, input logic [2:0] rs, rt, dst,
                             input logic rw, mr, mw, hl, vl);
    dx_t d;
    d = '{rsd, rtd, imm, pc, op, fn, rs, rt, dst, rw, mr, mw, hl, vl};
    return d;
  endfunction

  dx_t BUB;
  initial BUB = mk(16'h0, 16'h0, 16'h0, 16'h0, 5'h01, 2'd0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0);

  // Drive one cycle of inputs, check Stall before the edge, queue the expected D/X.
  task automatic step(input string name, input logic r, input logic [15:0] ins, pc,
                      input logic fl, wbe, input logic [2:0] wbr, input logic [15:0] wbd,
                      input logic exp_stall, input dx_t exp);
    @(negedge clk);
    rst = r; Instr = ins; IncPC = pc; Flush = fl;
    WbRegWrite = wbe; WbReg = wbr; WbData = wbd;
    #1;
    total++;
    if (Stall === exp_stall) passed++;
    else $display("FAIL %s stall: got %b want %b", name, Stall, exp_stall);
    sb.push_back(exp);
  endtask

  // Monitor: one expectation per edge, sampled 1 time unit after posedge.
  initial begin
    dx_t act, exp;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        act = '{RsData_Out, RtData_Out, Imm_Out, IncPC_Out, Opcode_Out, Funct_Out,
                Rs_Out, Rt_Out, DestReg_Out, RegWrite_Out, MemRead_Out, MemWrite_Out,
                Halt_Out, Valid_Out};
        total++;
        if (act === exp) passed++;
        else $display("FAIL dx @%0t: got %h want %h", $time, act, exp);
      end
    end
  end

  initial begin
    int guard;
    @(posedge clk);  // first reset edge, state unknown before it
    // Reset held with arbitrary instruction
    step("rst0", 1, 16'hDA64, 16'h0102, 0, 0, 3'd0, 16'h0, 0, BUB);
    step("rst1", 1, 16'hDA64, 16'h0102, 0, 0, 3'd0, 16'h0, 0, BUB);
    // ADD R1,R2,R3 after reset: registers read zero
    step("add", 0, 16'hDA64, 16'h0102, 0, 0, 3'd0, 16'h0, 0,
         mk(16'h0, 16'h0, 16'h0, 16'h0102, 5'h1B, 2'd0, 3'd2, 3'd3, 3'd1, 1, 0, 0, 0, 1));
    // ADD R1,R3,R3 with same-cycle WB of R3
    step("bypass", 0, 16'hDB64, 16'h0104, 0, 1, 3'd3, 16'hBEEF, 0,
         mk(16'hBEEF, 16'hBEEF, 16'h0, 16'h0104, 5'h1B, 2'd0, 3'd3, 3'd3, 3'd1, 1, 0, 0, 0, 1));
    // LD R2,R1,0
    step("ld", 0, 16'h8940, 16'h0106, 0, 0, 3'd0, 16'h0, 0,
         mk(16'h0, 16'h0, 16'h0, 16'h0106, 5'h11, 2'd0, 3'd1, 3'd2, 3'd2, 1, 1, 0, 0, 1));
    // ADDI R4,R2,1: load-use stall, then issue
    step("addi_stall", 0, 16'h4281, 16'h0108, 0, 0, 3'd0, 16'h0, 1, BUB);
    step("addi_go", 0, 16'h4281, 16'h0108, 0, 0, 3'd0, 16'h0, 0,
         mk(16'h0, 16'h0, 16'h0001, 16'h0108, 5'h08, 2'd1, 3'd2, 3'd4, 3'd4, 1, 0, 0, 0, 1));
    // Load-use again, but flushed in the hazard cycle
    step("ld2", 0, 16'h8940, 16'h010A, 0, 0, 3'd0, 16'h0, 0,
         mk(16'h0, 16'h0, 16'h0, 16'h010A, 5'h11, 2'd0, 3'd1, 3'd2, 3'd2, 1, 1, 0, 0, 1));
    step("flush", 0, 16'h4281, 16'h010C, 1, 0, 3'd0, 16'h0, 0, BUB);
    // ADDI with bypassed WB of R2
    step("addi_wb", 0, 16'h4281, 16'h0110, 0, 1, 3'd2, 16'h1234, 0,
         mk(16'h1234, 16'h0, 16'h0001, 16'h0110, 5'h08, 2'd1, 3'd2, 3'd4, 3'd4, 1, 0, 0, 0, 1));
    // Immediate extensions
    step("subi", 0, 16'h4C3F, 16'h0112, 0, 0, 3'd0, 16'h0, 0,
         mk(16'h0, 16'h0, 16'hFFFF, 16'h0112, 5'h09, 2'd3, 3'd4, 3'd1, 3'd1, 1, 0, 0, 0, 1));
    step("xori", 0, 16'h503F, 16'h0114, 0, 0, 3'd0, 16'h0, 0,
         mk(16'h0, 16'h0, 16'h001F, 16'h0114, 5'h0A, 2'd3, 3'd0, 3'd1, 3'd1, 1, 0, 0, 0, 1));
    step("j", 0, 16'h2400, 16'h0116, 0, 0, 3'd0, 16'h0, 0,
         mk(16'h0, 16'h0, 16'hFC00, 16'h0116, 5'h04, 2'd0, 3'd4, 3'd0, 3'd0, 0, 0, 0, 0, 1));
    step("jal", 0, 16'h3000, 16'h0118, 0, 0, 3'd0, 16'h0, 0,
         mk(16'h0, 16'h0, 16'h0000, 16'h0118, 5'h06, 2'd0, 3'd0, 3'd0, 3'd7, 1, 0, 0, 0, 1));
    // ST R2 -> [R3+2]: register file holds R3=BEEF, R2=1234
    step("st", 0, 16'h8342, 16'h011A, 0, 0, 3'd0, 16'h0, 0,
         mk(16'hBEEF, 16'h1234, 16'h0002, 16'h011A, 5'h10, 2'd2, 3'd3, 3'd2, 3'd0, 0, 0, 1, 0, 1));
    // LBI R5,0x80
    step("lbi", 0, 16'hC580, 16'h011C, 0, 0, 3'd0, 16'h0, 0,
         mk(16'h0, 16'h0, 16'hFF80, 16'h011C, 5'h18, 2'd0, 3'd5, 3'd4, 3'd5, 1, 0, 0, 0, 1));
    step("halt", 0, 16'h0000, 16'h011E, 0, 0, 3'd0, 16'h0, 0,
         mk(16'h0, 16'h0, 16'h0, 16'h011E, 5'h00, 2'd0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1, 1));
    // Reset clears the register file: R3 reads zero afterwards
    step("rst2", 1, 16'hDB64, 16'h0120, 0, 0, 3'd0, 16'h0, 0, BUB);
    step("add_clr", 0, 16'hDB64, 16'h0122, 0, 0, 3'd0, 16'h0, 0,
         mk(16'h0, 16'h0, 16'h0, 16'h0122, 5'h1B, 2'd0, 3'd3, 3'd3, 3'd1, 1, 0, 0, 0, 1));

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (sb.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
